image_eth_deformatter: RTL

// - Receive-side counterpart of the line packer: pops line records from a byte FIFO
//   (1-cycle read latency) and regenerates a 1-bit Sobel pixel stream with valid/hsync/vsync.
// - Sits between the Ethernet RX FIFO read port and the binary-image display/check path.
// - Record = HDR0, HDR1, then IMG_WIDTH/8 payload bytes.
// - HDR0 = {SOF, EOF, 6'h2A}; HDR1 = line index [7:0]; payload pixels are MSB-first.

---
 rtl/image_eth_pkg.sv | 22 ++
 rtl/eth_byte_serializer.sv | 50 +++++
 rtl/image_eth_deformatter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/image_eth_pkg.sv
// Shared definitions for the Ethernet line packer / deformatter pair.
// HDR0 = {SOF, EOF, HDR_MARKER}; HDR1 = line index; then IMG_WIDTH/8 payload bytes.
package image_eth_pkg;

  localparam logic [5:0]  HDR_MARKER = 6'h2A;
  localparam int unsigned SOF_BIT    = 7;
  localparam int unsigned EOF_BIT    = 6;
  localparam int unsigned HDR_BYTES  = 2;

  typedef enum logic [2:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StLine,
    StGap
  } deform_state_e;

  function automatic logic hdr_marker_ok(input logic [7:0] b);
    return b[5:0] == HDR_MARKER;
  endfunction

endpackage

// File: rtl/eth_byte_serializer.sv
// 8-bit MSB-first shift register.
// Ports:
//   clk_pixel, rst_n   clock and async active-low reset
//   i_load, i_data     load a new byte (wins over a simultaneous shift)
//   i_shift            advance one bit
//   o_bit              current bit (bit 7 of the register)
//   o_empty            no bits left
//   o_last             exactly one bit left
//   o_low              at most two bits left (prefetch window)
module eth_byte_serializer (
  input  logic       clk_pixel,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_shift,
  output logic       o_bit,
  output logic       o_empty,
  output logic       o_last,
  output logic       o_low
);

  logic [7:0] r_sh;
  logic [2:0] r_cnt;   // bits remaining minus one, meaningful while r_full
  logic       r_full;

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      r_sh   <= 8'h00;
      r_cnt  <= 3'd0;
      r_full <= 1'b0;
    end else if (i_load) begin
      r_sh   <= i_data;
      r_cnt  <= 3'd7;
      r_full <= 1'b1;
    end else if (i_shift && r_full) begin
      r_sh <= {r_sh[6:0], 1'b0};
      if (r_cnt == 3'd0) begin
        r_full <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

  assign o_bit   = r_sh[7];
  assign o_empty = !r_full;
  assign o_last  = r_full && (r_cnt == 3'd0);
  assign o_low   = !r_full || (r_cnt <= 3'd1);

endmodule

// File: rtl/image_eth_deformatter.sv
// Pops line records from a byte FIFO (1-cycle read latency) and regenerates a
// 1-bit pixel stream with valid/hsync/vsync.
// Ports:
//   clk_pixel, rst_n            pixel/FIFO read clock, async active-low reset
//   fifo_empty, fifo_usedw      FIFO status
//   read_data, read_req         FIFO data (valid the cycle after read_req) and pop strobe
//   valid, hsync, vsync, sobel  pixel stream
//   line_idx                    HDR1 of the line being emitted
//   hdr_err, frame_done         1-cycle status pulses
module image_eth_deformatter
  import image_eth_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = 16,
  parameter int unsigned USEDW_W   = 10,
  parameter int unsigned LINE_GAP  = 3
) (
  input  logic               clk_pixel,
  input  logic               rst_n,
  input  logic               fifo_empty,
  input  logic [USEDW_W-1:0] fifo_usedw,
  input  logic [7:0]         read_data,
  output logic               read_req,
  output logic               valid,
  output logic               hsync,
  output logic               vsync,
  output logic               sobel,
  output logic [7:0]         line_idx,
  output logic               hdr_err,
  output logic               frame_done
);

  localparam int unsigned BYTES = IMG_WIDTH / 8;
  localparam int unsigned BC_W  = $clog2(BYTES) + 1;
  localparam int unsigned GAP_W = $clog2(LINE_GAP + 1);
  localparam logic [USEDW_W-1:0] REC_WORDS = USEDW_W'(BYTES + HDR_BYTES);

  deform_state_e r_state, w_state_nxt;

  logic            r_pend;      // a pop was issued last cycle, read_data is valid now
  logic            r_sof, r_eof;
  logic            r_vs, r_hs_act;
  logic            r_hdr_err, r_frame_done;
  logic [7:0]      r_line_idx;
  logic [BC_W-1:0] r_bytes_left; // payload bytes still to pop
  logic [GAP_W-1:0] r_gap_cnt;

  logic w_read_req, w_load, w_shift, w_valid;
  logic w_hdr_err_set, w_fd_set, w_latch_hdr0, w_latch_hdr1;
  logic w_ser_bit, w_ser_empty, w_ser_last, w_ser_low;

  eth_byte_serializer u_ser (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_data    (read_data),
    .i_shift   (w_shift),
    .o_bit     (w_ser_bit),
    .o_empty   (w_ser_empty),
    .o_last    (w_ser_last),
    .o_low     (w_ser_low)
  );

  assign w_valid = (r_state == StLine) && !w_ser_empty;

  always_comb begin
    w_state_nxt   = r_state;
    w_read_req    = 1'b0;
    w_load        = 1'b0;
    w_shift       = 1'b0;
    w_hdr_err_set = 1'b0;
    w_fd_set      = 1'b0;
    w_latch_hdr0  = 1'b0;
    w_latch_hdr1  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if ((fifo_usedw >= REC_WORDS) && !fifo_empty) begin
          w_read_req  = 1'b1;
          w_state_nxt = StHdr0;
        end
      end
      StHdr0: begin
        if (!r_pend) begin
          w_state_nxt = StIdle;
        end else if (hdr_marker_ok(read_data)) begin
          w_latch_hdr0 = 1'b1;
          // New frame while the previous one never saw its EOF.
          if (read_data[SOF_BIT] && r_vs) w_hdr_err_set = 1'b1;
          w_read_req  = !fifo_empty;
          w_state_nxt = StHdr1;
        end else begin
          // Drop the byte and keep hunting for a marker.
          w_hdr_err_set = 1'b1;
          if (fifo_empty) w_state_nxt = StIdle;
          else            w_read_req  = 1'b1;
        end
      end
      StHdr1: begin
        w_read_req = !fifo_empty;
        if (r_pend) begin
          w_latch_hdr1 = 1'b1;
          if (r_sof) w_hdr_err_set = (read_data != 8'd0);
          else       w_hdr_err_set = (read_data != 8'(r_line_idx + 8'd1));
          w_state_nxt = StLine;
        end
      end
      StLine: begin
        w_load     = r_pend;
        w_shift    = !w_ser_empty;
        // Pop when two bits remain so the byte lands as the last bit shifts out.
        w_read_req = (r_bytes_left != '0) && !r_pend && !fifo_empty && w_ser_low;
        if (w_ser_last && !r_pend && (r_bytes_left == '0)) begin
          w_fd_set    = r_eof;
          w_state_nxt = StGap;
        end
      end
      StGap: begin
        if (r_gap_cnt == GAP_W'(LINE_GAP - 1)) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_pend       <= 1'b0;
      r_sof        <= 1'b0;
      r_eof        <= 1'b0;
      r_vs         <= 1'b0;
      r_hs_act     <= 1'b0;
      r_hdr_err    <= 1'b0;
      r_frame_done <= 1'b0;
      r_line_idx   <= 8'd0;
      r_bytes_left <= '0;
      r_gap_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pend       <= w_read_req;
      r_hdr_err    <= w_hdr_err_set;
      r_frame_done <= w_fd_set;
      if (w_latch_hdr0) begin
        r_sof <= read_data[SOF_BIT];
        r_eof <= read_data[EOF_BIT];
      end
      if (w_latch_hdr1) begin
        r_line_idx   <= read_data;
        r_bytes_left <= BC_W'(BYTES) - {{(BC_W-1){1'b0}}, w_read_req};
      end else if ((r_state == StLine) && w_read_req) begin
        r_bytes_left <= r_bytes_left - BC_W'(1);
      end
      if (r_state != StLine) r_hs_act <= 1'b0;
      else if (w_valid)      r_hs_act <= 1'b1;
      if (w_valid && r_sof) r_vs <= 1'b1;
      if (w_fd_set)         r_vs <= 1'b0;
      if (r_state == StGap) r_gap_cnt <= r_gap_cnt + GAP_W'(1);
      else                  r_gap_cnt <= '0;
    end
  end

  // Gated so the FIFO is never popped while reset is held.
  assign read_req   = w_read_req & rst_n;
  assign valid      = w_valid;
  assign sobel      = w_valid & w_ser_bit;
  assign hsync      = (r_state == StLine) && (w_valid || r_hs_act);
  assign vsync      = r_vs || (w_valid && r_sof);
  assign line_idx   = r_line_idx;
  assign hdr_err    = r_hdr_err;
  assign frame_done = r_frame_done;

endmodule
